png_filter: RTL and testbench



---
 rtl/png_filter.sv | 160 ++++++++++++++++
 tb/tb_png_filter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/png_filter.sv
// png_filter: per-scanline PNG filter stage in front of an external
// single-port row-buffer fifo.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   cfg_w_i/h_i/typ_i image width (bytes), height (rows), filter type;
//                     latched on start_i while idle
//   start_i           one-cycle pulse that begins an image
//   dat_val_i/rdy_o/i raw byte input handshake
//   fifo_wr_*         row-buffer write (current raw byte)
//   fifo_rd_val_o     row-buffer read strobe; data on fifo_rd_dat_i next cycle
//   out_val_o/dat_o   filtered stream: type byte then cfg_w bytes per row
//   done_o            one-cycle pulse after the last byte of the image
module png_filter #(
   parameter int SIZE_W_WD = 9,
   parameter int SIZE_H_WD = 12,
   parameter int DATA_WD   = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [SIZE_W_WD-1:0] cfg_w_i,
   input  logic [SIZE_H_WD-1:0] cfg_h_i,
   input  logic [2:0]           cfg_typ_i,
   input  logic                 start_i,
   input  logic                 dat_val_i,
   output logic                 dat_rdy_o,
   input  logic [DATA_WD-1:0]   dat_i,
   output logic                 fifo_wr_val_o,
   output logic [DATA_WD-1:0]   fifo_wr_dat_o,
   output logic                 fifo_rd_val_o,
   input  logic [DATA_WD-1:0]   fifo_rd_dat_i,
   output logic                 out_val_o,
   output logic [DATA_WD-1:0]   out_dat_o,
   output logic                 done_o
);

   typedef enum logic [2:0] {S_IDLE, S_TYPE, S_RD, S_WR, S_DONE} state_t;

   state_t               state, nxt;
   logic [SIZE_W_WD-1:0] w_q, col_q;
   logic [SIZE_H_WD-1:0] h_q, row_q;
   logic [2:0]           typ_q;
   logic [DATA_WD-1:0]   a_q, c_q, x_q;

   logic                 last_col, last_row;
   logic [DATA_WD-1:0]   b_val, pred, filt;
   logic [DATA_WD:0]     sum_ab;
   logic signed [9:0]    dpa, dpb, dpc;
   logic [9:0]           pa, pb, pc;

   assign last_col = (col_q == w_q - SIZE_W_WD'(1));
   assign last_row = (row_q == h_q - SIZE_H_WD'(1));

   // Row 0 has no previous row in the fifo: the "up" neighbours are zero.
   assign b_val  = (row_q == '0) ? '0 : fifo_rd_dat_i;
   assign sum_ab = {1'b0, a_q} + {1'b0, b_val};

   // Paeth distances in 10-bit signed so a+b-2c cannot overflow.
   assign dpa = $signed({2'b00, b_val}) - $signed({2'b00, c_q});
   assign dpb = $signed({2'b00, a_q})   - $signed({2'b00, c_q});
   assign dpc = $signed({2'b00, a_q}) + $signed({2'b00, b_val})
              - $signed({1'b0, c_q, 1'b0});
   assign pa  = dpa[9] ? 10'(-dpa) : 10'(dpa);
   assign pb  = dpb[9] ? 10'(-dpb) : 10'(dpb);
   assign pc  = dpc[9] ? 10'(-dpc) : 10'(dpc);

   always_comb begin
      pred = '0;
      case (typ_q)
         3'd1:    pred = a_q;
         3'd2:    pred = b_val;
         3'd3:    pred = sum_ab[DATA_WD:1];
         3'd4: begin
            if (pa <= pb && pa <= pc) pred = a_q;
            else if (pb <= pc)        pred = b_val;
            else                      pred = c_q;
         end
         default: pred = '0;
      endcase
      filt = x_q - pred;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         w_q   <= '0;
         h_q   <= '0;
         typ_q <= '0;
         col_q <= '0;
         row_q <= '0;
         a_q   <= '0;
         c_q   <= '0;
         x_q   <= '0;
      end else begin
         state <= nxt;
         case (state)
            S_IDLE: if (start_i) begin
               w_q   <= cfg_w_i;
               h_q   <= cfg_h_i;
               typ_q <= (cfg_typ_i > 3'd4) ? 3'd0 : cfg_typ_i;
            end
            S_TYPE: begin
               col_q <= '0;
               a_q   <= '0;
               c_q   <= '0;
            end
            S_RD: if (dat_val_i) x_q <= dat_i;
            S_WR: begin
               a_q <= x_q;
               c_q <= b_val;
               if (!last_col)      col_q <= col_q + SIZE_W_WD'(1);
               else if (!last_row) row_q <= row_q + SIZE_H_WD'(1);
            end
            S_DONE: row_q <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      nxt           = state;
      dat_rdy_o     = 1'b0;
      fifo_rd_val_o = 1'b0;
      fifo_wr_val_o = 1'b0;
      fifo_wr_dat_o = '0;
      out_val_o     = 1'b0;
      out_dat_o     = '0;
      done_o        = 1'b0;
      case (state)
         S_IDLE: if (start_i) nxt = S_TYPE;
         S_TYPE: begin
            out_val_o = 1'b1;
            out_dat_o = {{(DATA_WD-3){1'b0}}, typ_q};
            nxt       = S_RD;
         end
         S_RD: begin
            dat_rdy_o = 1'b1;
            if (dat_val_i) begin
               fifo_rd_val_o = (row_q != '0);
               nxt           = S_WR;
            end
         end
         S_WR: begin
            fifo_wr_val_o = 1'b1;
            fifo_wr_dat_o = x_q;
            out_val_o     = 1'b1;
            out_dat_o     = filt;
            if (!last_col)     nxt = S_RD;
            else if (last_row) nxt = S_DONE;
            else               nxt = S_TYPE;
         end
         S_DONE: begin
            done_o = 1'b1;
            nxt    = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_png_filter.sv
// tb_png_filter: directed and randomized checks of png_filter against a
// row/column reference of the PNG filter rules, with a behavioural
// circular row-buffer fifo attached to the fifo ports.
module tb_png_filter;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [8:0] cfg_w_i = '0;
   logic [11:0] cfg_h_i = '0;
   logic [2:0] cfg_typ_i = '0;
   logic       start_i = 1'b0;
   logic       dat_val_i = 1'b0;
   logic       dat_rdy_o;
   logic [7:0] dat_i = '0;
   logic       fifo_wr_val_o;
   logic [7:0] fifo_wr_dat_o;
   logic       fifo_rd_val_o;
   logic [7:0] fifo_rd_dat_i;
   logic       out_val_o;
   logic [7:0] out_dat_o;
   logic       done_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   png_filter #(.SIZE_W_WD(9), .SIZE_H_WD(12), .DATA_WD(8)) dut (
      .clk(clk), .rstn(rstn),
      .cfg_w_i(cfg_w_i), .cfg_h_i(cfg_h_i), .cfg_typ_i(cfg_typ_i),
      .start_i(start_i),
      .dat_val_i(dat_val_i), .dat_rdy_o(dat_rdy_o), .dat_i(dat_i),
      .fifo_wr_val_o(fifo_wr_val_o), .fifo_wr_dat_o(fifo_wr_dat_o),
      .fifo_rd_val_o(fifo_rd_val_o), .fifo_rd_dat_i(fifo_rd_dat_i),
      .out_val_o(out_val_o), .out_dat_o(out_dat_o), .done_o(done_o)
   );

   // Row-buffer fifo: circular, depth = current image width, shares rstn.
   logic [7:0] mem [0:511];
   int wp, rp;
   int fw = 1;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp <= 0;
         rp <= 0;
         fifo_rd_dat_i <= '0;
      end else begin
         if (fifo_wr_val_o) begin
            mem[wp] <= fifo_wr_dat_o;
            wp <= (wp + 1 >= fw) ? 0 : wp + 1;
         end
         if (fifo_rd_val_o) begin
            fifo_rd_dat_i <= mem[rp];
            rp <= (rp + 1 >= fw) ? 0 : rp + 1;
         end
      end
   end

   // Monitor, sampled on the falling edge.
   logic [7:0] got [$];
   int done_cnt = 0, rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, stray_rd = 0;
   always @(negedge clk) begin
      if (rstn) begin
         if (out_val_o) got.push_back(out_dat_o);
         if (done_o) done_cnt++;
         if (fifo_rd_val_o) rd_cnt++;
         if (fifo_wr_val_o) wr_cnt++;
         if (fifo_rd_val_o && fifo_wr_val_o) overlap_cnt++;
         if (fifo_rd_val_o && !dat_val_i) stray_rd++;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] img [0:7][0:7];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // PNG filter rules applied to plain neighbour values.
   function automatic int ref_filt(int typ, int x, int a, int b, int c);
      int p, pa, pb, pc, pred;
      case (typ)
         1: pred = a;
         2: pred = b;
         3: pred = (a + b) / 2;
         4: begin
            p  = a + b - c;
            pa = (p > a) ? p - a : a - p;
            pb = (p > b) ? p - b : b - p;
            pc = (p > c) ? p - c : c - p;
            if (pa <= pb && pa <= pc) pred = a;
            else if (pb <= pc)        pred = b;
            else                      pred = c;
         end
         default: pred = 0;
      endcase
      return (x - pred) & 255;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input int stall);
      int t;
      bit ok;
      dat_val_i = 1'b0;
      repeat (stall) tick();
      dat_val_i = 1'b1;
      dat_i = v;
      ok = 0;
      for (t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (dat_rdy_o) begin
            tick();
            ok = 1;
         end
      end
      dat_val_i = 1'b0;
      if (!ok) chk("input_handshake_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_image(input int w, input int h, input int typ_in,
                            input int stall, input bit mid_start);
      int exp_q [$];
      int etyp, a, b, c, t;
      int b_got, b_done, b_rd, b_wr, b_ov, b_stray;
      etyp = (typ_in > 4) ? 0 : typ_in;
      for (int r = 0; r < h; r++) begin
         exp_q.push_back(etyp);
         for (int col = 0; col < w; col++) begin
            a = (col == 0) ? 0 : int'(img[r][col-1]);
            b = (r == 0) ? 0 : int'(img[r-1][col]);
            c = (r == 0 || col == 0) ? 0 : int'(img[r-1][col-1]);
            exp_q.push_back(ref_filt(etyp, int'(img[r][col]), a, b, c));
         end
      end
      fw = w;
      cfg_w_i = 9'(w);
      cfg_h_i = 12'(h);
      cfg_typ_i = 3'(typ_in);
      b_got = got.size(); b_done = done_cnt; b_rd = rd_cnt; b_wr = wr_cnt;
      b_ov = overlap_cnt; b_stray = stray_rd;
      pulse_start();
      for (int r = 0; r < h; r++) begin
         for (int col = 0; col < w; col++) begin
            if (mid_start && r == 0 && col == 1) begin
               cfg_w_i = 9'd3;
               cfg_typ_i = 3'd1;
               pulse_start();
            end
            send_byte(img[r][col], stall);
         end
      end
      t = 0;
      while (done_cnt == b_done && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (3) tick();
      chk("done_pulse_count", 32'(done_cnt - b_done), 32'd1);
      chk("out_len", 32'(got.size() - b_got), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (b_got + i < got.size())
            chk($sformatf("out[%0d]", i), 32'(got[b_got+i]), 32'(exp_q[i]));
      chk("fifo_rd_count", 32'(rd_cnt - b_rd), 32'(w * (h - 1)));
      chk("fifo_wr_count", 32'(wr_cnt - b_wr), 32'(w * h));
      chk("fifo_rd_wr_overlap", 32'(overlap_cnt - b_ov), 32'd0);
      chk("fifo_rd_while_stalled", 32'(stray_rd - b_stray), 32'd0);
      chk("idle_after_image", 32'(dat_rdy_o), 32'd0);
   endtask

   task automatic load2(input int r, input int v0, input int v1, input int v2, input int v3);
      img[r][0] = 8'(v0); img[r][1] = 8'(v1); img[r][2] = 8'(v2); img[r][3] = 8'(v3);
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      chk("rst_out_val", 32'(out_val_o), 32'd0);
      chk("rst_rdy", 32'(dat_rdy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_fifo_strobes", 32'({fifo_rd_val_o, fifo_wr_val_o}), 32'd0);
      rstn = 1'b1;
      repeat (2) tick();

      // Sub: 1,10,10,10,10,1,5,0,0,0
      load2(0, 10, 20, 30, 40); load2(1, 5, 5, 5, 5);
      run_image(4, 2, 1, 0, 0);
      // Up: 2,10,20,30,40,2,5,5,5,5
      load2(0, 10, 20, 30, 40); load2(1, 15, 25, 35, 45);
      run_image(4, 2, 2, 0, 0);
      // Avg: 3,10,15,3,25,15
      load2(0, 10, 20, 0, 0); load2(1, 30, 40, 0, 0);
      run_image(2, 2, 3, 0, 0);
      // Paeth: 4,100,100,4,206,116
      load2(0, 100, 200, 0, 0); load2(1, 50, 60, 0, 0);
      run_image(2, 2, 4, 0, 0);
      // Width 1, stalled input, then an identical back-to-back image
      img[0][0] = 8'd77; img[1][0] = 8'd3; img[2][0] = 8'd250;
      run_image(1, 3, 0, 5, 0);
      run_image(1, 3, 0, 5, 0);

      // Reset in the middle of row 1 of an Up image
      load2(0, 10, 20, 30, 40); load2(1, 15, 25, 35, 45);
      fw = 4; cfg_w_i = 9'd4; cfg_h_i = 12'd2; cfg_typ_i = 3'd2;
      pulse_start();
      for (int col = 0; col < 4; col++) send_byte(img[0][col], 0);
      send_byte(img[1][0], 0);
      send_byte(img[1][1], 0);
      rstn = 1'b0;
      #1;
      chk("midrst_out_val", 32'(out_val_o), 32'd0);
      chk("midrst_fifo_strobes", 32'({fifo_rd_val_o, fifo_wr_val_o}), 32'd0);
      repeat (2) tick();
      rstn = 1'b1;
      tick();
      chk("midrst_idle", 32'(dat_rdy_o), 32'd0);
      run_image(4, 2, 2, 0, 0);

      // start_i pulsed mid-image with different cfg must be ignored
      load2(0, 10, 20, 30, 40); load2(1, 15, 25, 35, 45);
      run_image(4, 2, 2, 1, 1);

      // Randomized images, including reserved types 5..7
      for (int n = 0; n < 8; n++) begin
         int w, h, typ, st;
         w   = $urandom_range(1, 8);
         h   = $urandom_range(1, 4);
         typ = $urandom_range(0, 7);
         st  = $urandom_range(0, 2);
         for (int r = 0; r < 8; r++)
            for (int col = 0; col < 8; col++)
               img[r][col] = 8'($urandom);
         run_image(w, h, typ, st, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
